// File: rtl/space_pkg.sv
// rtl/space_pkg.sv - shared playfield constants, coordinate defaults and laser FSM states
package space_pkg;

  localparam int CORDW   = 10;
  localparam int START_Y = 392;
  localparam int TOP_Y   = 16;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  typedef enum logic {
    IDLE,
    FLY
  } laser_state_e;

endpackage

// File: rtl/rect_hit.sv
// rtl/rect_hit.sv - combinational point-in-rectangle test, one bit wider than coordinates
module rect_hit #(
  parameter int CORDW = 10
) (
  input  logic [CORDW-1:0] x,
  input  logic [CORDW-1:0] y,
  input  logic [CORDW-1:0] left,
  input  logic [CORDW-1:0] top,
  input  logic [CORDW-1:0] w,
  input  logic [CORDW-1:0] h,
  output logic             in
);

  // Extra bit keeps left+w from wrapping at the right/bottom edge of the coordinate space
  logic [CORDW:0] x_e, y_e, left_e, top_e, right_e, bottom_e;

  assign x_e      = {1'b0, x};
  assign y_e      = {1'b0, y};
  assign left_e   = {1'b0, left};
  assign top_e    = {1'b0, top};
  assign right_e  = left_e + {1'b0, w};
  assign bottom_e = top_e + {1'b0, h};

  assign in = (x_e >= left_e) && (x_e < right_e) && (y_e >= top_e) && (y_e < bottom_e);

endmodule

// File: rtl/player_laser.sv
// rtl/player_laser.sv - single-shot player laser; PLAYER_LASER_QUEUE_EN adds a one-entry pending shot
module player_laser #(
  parameter int LASER_W = 2,
  parameter int LASER_H = 8,
  parameter int START_Y = space_pkg::START_Y,
  parameter int TOP_Y   = space_pkg::TOP_Y,
  parameter int SPEED   = 4,
  parameter int CORDW   = space_pkg::CORDW
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             frame_i,
  input  logic             fire_i,
  input  logic [CORDW-1:0] gun_pos_i,
  input  logic             hit_i,
  input  logic [CORDW-1:0] x_i,
  input  logic [CORDW-1:0] y_i,
  output logic             laser_active_o,
  output logic [CORDW-1:0] laser_x_o,
  output logic [CORDW-1:0] laser_y_o,
  output logic             laser_area_o,
  output logic             retire_o
);

  import space_pkg::*;

  localparam logic [CORDW-1:0] HALF_W   = CORDW'(LASER_W / 2);
  localparam logic [CORDW-1:0] STEP     = CORDW'(SPEED);
  localparam logic [CORDW-1:0] EXPIRE_Y = CORDW'(TOP_Y + SPEED);
  localparam logic [CORDW-1:0] LAUNCH_Y = CORDW'(START_Y);

  laser_state_e     state, state_n;
  logic [CORDW-1:0] x_q, x_n, y_q, y_n;
  logic             retire_q, retire_n;
  logic             launch;
  logic [CORDW-1:0] launch_col;
  logic             in_rect;

`ifdef PLAYER_LASER_QUEUE_EN
  logic             pend_q, pend_n;
  logic [CORDW-1:0] pend_col_q, pend_col_n;

  // A stored shot takes precedence over a fresh fire_i when the FSM is idle
  assign launch     = pend_q || fire_i;
  assign launch_col = pend_q ? pend_col_q : gun_pos_i;

  always_comb begin
    pend_n     = pend_q;
    pend_col_n = pend_col_q;
    if (state == IDLE && pend_q) begin
      pend_n = 1'b0;
    end else if (state == FLY && fire_i && !pend_q) begin
      pend_n     = 1'b1;
      pend_col_n = gun_pos_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q     <= 1'b0;
      pend_col_q <= '0;
    end else begin
      pend_q     <= pend_n;
      pend_col_q <= pend_col_n;
    end
  end
`else
  assign launch     = fire_i;
  assign launch_col = gun_pos_i;
`endif

  always_comb begin
    state_n  = state;
    x_n      = x_q;
    y_n      = y_q;
    retire_n = 1'b0;
    case (state)
      IDLE: begin
        if (launch) begin
          state_n = FLY;
          y_n     = LAUNCH_Y;
          x_n     = (launch_col < HALF_W) ? '0 : launch_col - HALF_W;
        end
      end
      FLY: begin
        if (hit_i) begin
          state_n  = IDLE;
          retire_n = 1'b1;
        end else if (frame_i) begin
          if (y_q < EXPIRE_Y) begin
            state_n  = IDLE;
            retire_n = 1'b1;
          end else begin
            y_n = y_q - STEP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      retire_q <= 1'b0;
    end else begin
      state    <= state_n;
      x_q      <= x_n;
      y_q      <= y_n;
      retire_q <= retire_n;
    end
  end

  rect_hit #(
    .CORDW(CORDW)
  ) u_rect (
    .x   (x_i),
    .y   (y_i),
    .left(x_q),
    .top (y_q),
    .w   (CORDW'(LASER_W)),
    .h   (CORDW'(LASER_H)),
    .in  (in_rect)
  );

  assign laser_active_o = (state == FLY);
  assign laser_x_o      = x_q;
  assign laser_y_o      = y_q;
  assign retire_o       = retire_q;
  assign laser_area_o   = (state == FLY) && in_rect;

endmodule

// File: tb/tb_player_laser.sv
// tb/tb_player_laser.sv - scoreboard bench for player_laser; honours PLAYER_LASER_QUEUE_EN
module tb_player_laser;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       frame_i = 1'b0;
  logic       fire_i = 1'b0;
  logic [9:0] gun_pos_i = '0;
  logic       hit_i = 1'b0;
  logic [9:0] x_i = 10'd1023;
  logic [9:0] y_i = 10'd1023;
  logic       laser_active_o;
  logic [9:0] laser_x_o;
  logic [9:0] laser_y_o;
  logic       laser_area_o;
  logic       retire_o;

  player_laser dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .frame_i       (frame_i),
    .fire_i        (fire_i),
    .gun_pos_i     (gun_pos_i),
    .hit_i         (hit_i),
    .x_i           (x_i),
    .y_i           (y_i),
    .laser_active_o(laser_active_o),
    .laser_x_o     (laser_x_o),
    .laser_y_o     (laser_y_o),
    .laser_area_o  (laser_area_o),
    .retire_o      (retire_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    string      name;
    logic       act;
    logic [9:0] x;
    logic [9:0] y;
    logic       ret;
    logic       area;
  } exp_t;

  exp_t q[$];
  int   rq[$];
  int   cyc = 0;
  int   ntests = 0;
  int   nfail = 0;
  exp_t e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic expect_out(input string name, input logic act, input int x, input int y,
                            input logic ret, input logic area);
    exp_t n;
    n.cyc  = cyc;
    n.name = name;
    n.act  = act;
    n.x    = 10'(x);
    n.y    = 10'(y);
    n.ret  = ret;
    n.area = area;
    q.push_back(n);
  endtask

  // Output monitor: compares every expectation scheduled for this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      ntests++;
      if (e.cyc < cyc || {laser_active_o, laser_x_o, laser_y_o, retire_o, laser_area_o} !==
          {e.act, e.x, e.y, e.ret, e.area}) begin
        nfail++;
        $display("FAIL %s: got act=%0d x=%0d y=%0d ret=%0d area=%0d, want act=%0d x=%0d y=%0d ret=%0d area=%0d",
                 e.name, laser_active_o, laser_x_o, laser_y_o, retire_o, laser_area_o,
                 e.act, e.x, e.y, e.ret, e.area);
      end
    end
  end

  // Retire monitor: every retire_o pulse must match a scheduled retire
  always @(negedge clk) begin
    while (rq.size() > 0 && rq[0] < cyc) begin
      void'(rq.pop_front());
      ntests++;
      nfail++;
      $display("FAIL retire_missing: got no pulse, want pulse at earlier cycle");
    end
    if (retire_o === 1'b1) begin
      ntests++;
      if (rq.size() > 0 && rq[0] == cyc) begin
        void'(rq.pop_front());
      end else begin
        nfail++;
        $display("FAIL retire_unexpected: got retire_o=1 at cycle %0d, want 0", cyc);
      end
    end
  end

  initial begin
    tick();
    tick();
    reset_i = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 0);

    gun_pos_i = 10'd320;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    expect_out("launch_320", 1, 319, 392, 0, 0);

    for (int i = 0; i < 3; i++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
      tick();
    end
    x_i = 10'd319; y_i = 10'd385;
    expect_out("area_in", 1, 319, 380, 0, 1);
    tick();
    x_i = 10'd321; y_i = 10'd385;
    expect_out("area_right_edge", 1, 319, 380, 0, 0);
    tick();
    x_i = 10'd319; y_i = 10'd388;
    expect_out("area_bottom_edge", 1, 319, 380, 0, 0);
    tick();
    x_i = 10'd320; y_i = 10'd387;
    expect_out("area_corner_in", 1, 319, 380, 0, 1);
    tick();
    x_i = 10'd1023; y_i = 10'd1023;

    for (int i = 0; i < 90; i++) begin
      frame_i = 1'b1;
      tick();
      frame_i = 1'b0;
    end
    expect_out("y_at_20", 1, 319, 20, 0, 0);
    frame_i = 1'b1;
    tick();
    expect_out("y_at_16", 1, 319, 16, 0, 0);
    tick();
    frame_i = 1'b0;
    rq.push_back(cyc);
    expect_out("expire", 0, 319, 16, 1, 0);
    tick();
    expect_out("expire_pulse_end", 0, 319, 16, 0, 0);

    gun_pos_i = 10'd100;
    fire_i = 1'b1;
    frame_i = 1'b1;
    tick();
    fire_i = 1'b0;
    expect_out("launch_with_frame", 1, 99, 392, 0, 0);
    tick();
    frame_i = 1'b0;
    expect_out("first_move", 1, 99, 388, 0, 0);
    hit_i = 1'b1;
    frame_i = 1'b1;
    tick();
    hit_i = 1'b0;
    frame_i = 1'b0;
    rq.push_back(cyc);
    expect_out("hit_over_frame", 0, 99, 388, 1, 0);
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    expect_out("hit_in_idle", 0, 99, 388, 0, 0);

    gun_pos_i = 10'd0;
    fire_i = 1'b1;
    tick();
    x_i = 10'd0; y_i = 10'd392;
    expect_out("launch_clamp", 1, 0, 392, 0, 1);
    gun_pos_i = 10'd200;
    tick();
    fire_i = 1'b0;
    x_i = 10'd1023; y_i = 10'd1023;
    expect_out("fire_in_fly", 1, 0, 392, 0, 0);
    tick();
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    rq.push_back(cyc);
    expect_out("hit_retire", 0, 0, 392, 1, 0);
    tick();
`ifdef PLAYER_LASER_QUEUE_EN
    expect_out("relaunch_queued", 1, 199, 392, 0, 0);
    hit_i = 1'b1;
    tick();
    hit_i = 1'b0;
    rq.push_back(cyc);
    expect_out("relaunch_retire", 0, 199, 392, 1, 0);
    tick();
`else
    expect_out("no_relaunch", 0, 0, 392, 0, 0);
`endif

    gun_pos_i = 10'd1023;
    fire_i = 1'b1;
    tick();
    fire_i = 1'b0;
    x_i = 10'd1023; y_i = 10'd399;
    expect_out("area_x1023", 1, 1022, 392, 0, 1);
    tick();
    y_i = 10'd400;
    expect_out("area_below", 1, 1022, 392, 0, 0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    x_i = 10'd1023; y_i = 10'd1023;
    expect_out("reset_mid_flight", 0, 0, 0, 0, 0);
    tick();
    expect_out("after_reset", 0, 0, 0, 0, 0);
    tick();
    tick();

    ntests++;
    if (q.size() != 0 || rq.size() != 0) begin
      nfail++;
      $display("FAIL drain: got %0d checks and %0d retires pending, want 0 and 0", q.size(), rq.size());
    end
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
